rgb888_stream_packer: RTL and testbench

- Upstream neighbour of the RAM-based RGB888 FIFO buffer.
- Accepts one 24-bit RGB888 pixel per cycle over a valid/ready handshake.
- Packs pixels byte-contiguously into 128-bit words and drives the FIFO write port (wren/wrdata), honouring the FIFO's full flag.
- A line/frame "last" marker flushes a partial word, zero-padded, so no pixel bytes remain stranded in the packer.

---
 rtl/rgb888_stream_packer_pkg.sv | 18 +
 rtl/rgb888_stream_packer_byte_merger.sv | 33 +++
 rtl/rgb888_stream_packer.sv | 119 +++++++++++
 tb/tb_rgb888_stream_packer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb888_stream_packer_pkg.sv
// Shared constants and state encoding for the RGB888 stream packer.
package rgb888_stream_packer_pkg;

    localparam int PIX_BYTES  = 3;
    localparam int WORD_BYTES = 16;
    localparam int BC_W       = 5;

    // Byte lanes of a pixel inside i_pix_data; B is the first byte on the stream.
    localparam int B_LANE = 0;
    localparam int G_LANE = 1;
    localparam int R_LANE = 2;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_FLUSH = 1'b1
    } pack_state_t;

endpackage

// File: rtl/rgb888_stream_packer_byte_merger.sv
// Places the three bytes of a pixel into the accumulator at byte offset bc and
// splits off any bytes that spill past the end of the word.
module rgb888_byte_merger
    import rgb888_stream_packer_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int PIX_W  = 24
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [BC_W-1:0]   bc,
    input  logic [PIX_W-1:0]  pix,
    output logic [DATA_W-1:0] word,
    output logic [PIX_W-9:0]  residual,
    output logic [BC_W-1:0]   bc_sum
);

    localparam int EXT_W = DATA_W + PIX_W - 8;

    logic [PIX_W-1:0] lanes;
    logic [EXT_W-1:0] pix_ext;
    logic [EXT_W-1:0] ext;

    // Accumulator bytes at and above bc are always zero, so OR-ing is a placement.
    always_comb begin
        lanes    = {pix[8*R_LANE +: 8], pix[8*G_LANE +: 8], pix[8*B_LANE +: 8]};
        pix_ext  = {{(EXT_W-PIX_W){1'b0}}, lanes} << {bc, 3'b000};
        ext      = {{(PIX_W-8){1'b0}}, acc} | pix_ext;
        word     = ext[DATA_W-1:0];
        residual = ext[EXT_W-1:DATA_W];
        bc_sum   = bc + BC_W'(PIX_BYTES);
    end

endmodule

// File: rtl/rgb888_stream_packer.sv
// Packs RGB888 pixels byte-contiguously into 128-bit FIFO words; a last marker
// flushes any partial word zero-padded.
module rgb888_stream_packer
    import rgb888_stream_packer_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int PIX_W  = 24,
    parameter int CNT_W  = 16
) (
    input  logic              system_clk,
    input  logic              rst_n,
    input  logic              i_pix_valid,
    input  logic [PIX_W-1:0]  i_pix_data,
    input  logic              i_pix_last,
    output logic              o_pix_ready,
    output logic              o_wren,
    output logic [DATA_W-1:0] o_wrdata,
    input  logic              i_full,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_word_cnt
);

    localparam int RES_W = PIX_W - 8;

    // Handshakes: a pixel moves when i_pix_valid & o_pix_ready; a word moves when
    // o_wren & !i_full, and o_wren/o_wrdata hold unchanged until that happens.
    pack_state_t       state_q, state_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] merged;
    logic [RES_W-1:0]  residual;
    logic [BC_W-1:0]   bc_sum;
    logic              accept;
    logic              word_ack;
    logic              overflow;

    rgb888_byte_merger #(
        .DATA_W (DATA_W),
        .PIX_W  (PIX_W)
    ) u_merger (
        .acc      (acc_q),
        .bc       (bc_q),
        .pix      (i_pix_data),
        .word     (merged),
        .residual (residual),
        .bc_sum   (bc_sum)
    );

    always_comb begin
        o_pix_ready = (state_q == ST_FILL) && !(wren_q && i_full);
        accept      = i_pix_valid && o_pix_ready;
        word_ack    = wren_q && !i_full;
        overflow    = (bc_sum >= BC_W'(WORD_BYTES));

        state_d  = state_q;
        bc_d     = bc_q;
        acc_d    = acc_q;
        wren_d   = wren_q && i_full;
        wrdata_d = wrdata_q;
        cnt_d    = word_ack ? cnt_q + CNT_W'(1) : cnt_q;

        if (state_q == ST_FLUSH) begin
            // The accumulator already holds the residual bytes, zero above them.
            if (word_ack) begin
                wren_d   = 1'b1;
                wrdata_d = acc_q;
                acc_d    = '0;
                bc_d     = '0;
                state_d  = ST_FILL;
            end
        end else if (accept) begin
            if (overflow) begin
                wren_d   = 1'b1;
                wrdata_d = merged;
                acc_d    = {{(DATA_W-RES_W){1'b0}}, residual};
                bc_d     = bc_sum - BC_W'(WORD_BYTES);
                if (i_pix_last && (bc_sum != BC_W'(WORD_BYTES))) begin
                    state_d = ST_FLUSH;
                end
            end else if (i_pix_last) begin
                wren_d   = 1'b1;
                wrdata_d = merged;
                acc_d    = '0;
                bc_d     = '0;
            end else begin
                acc_d = merged;
                bc_d  = bc_sum;
            end
        end

        o_wren     = wren_q;
        o_wrdata   = wrdata_q;
        o_word_cnt = cnt_q;
        o_busy     = (bc_q != '0) || wren_q || (state_q == ST_FLUSH);
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FILL;
            bc_q     <= '0;
            acc_q    <= '0;
            wren_q   <= 1'b0;
            wrdata_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            bc_q     <= bc_d;
            acc_q    <= acc_d;
            wren_q   <= wren_d;
            wrdata_q <= wrdata_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rgb888_stream_packer.sv
// Directed bench for rgb888_stream_packer: line packing, flush, backpressure,
// and asynchronous reset.
module tb_rgb888_stream_packer;

    logic         system_clk;
    logic         rst_n;
    logic         i_pix_valid;
    logic [23:0]  i_pix_data;
    logic         i_pix_last;
    logic         o_pix_ready;
    logic         o_wren;
    logic [127:0] o_wrdata;
    logic         i_full;
    logic         o_busy;
    logic [15:0]  o_word_cnt;

    int errors;
    int checks;
    bit tx_done;
    logic [127:0] got_q[$];
    logic [127:0] exp_q[$];

    localparam logic [127:0] W0 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] W1 = 128'h1F1E1D1C1B1A19181716151413121110;
    localparam logic [127:0] W2 = 128'h2F2E2D2C2B2A29282726252423222120;
    localparam logic [127:0] WP = 128'h000E0D0C0B0A09080706050403020100;
    localparam logic [127:0] WF = 128'h00000000000000000000000000001110;

    rgb888_stream_packer #(
        .DATA_W (128),
        .PIX_W  (24),
        .CNT_W  (16)
    ) dut (
        .system_clk  (system_clk),
        .rst_n       (rst_n),
        .i_pix_valid (i_pix_valid),
        .i_pix_data  (i_pix_data),
        .i_pix_last  (i_pix_last),
        .o_pix_ready (o_pix_ready),
        .o_wren      (o_wren),
        .o_wrdata    (o_wrdata),
        .i_full      (i_full),
        .o_busy      (o_busy),
        .o_word_cnt  (o_word_cnt)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    // Words the FIFO takes; inputs only change just after posedge, so negedge sees them settled.
    always @(negedge system_clk) begin
        if (rst_n && o_wren && !i_full) got_q.push_back(o_wrdata);
    end

    function automatic logic [23:0] pix(input int i);
        return {8'(3*i+2), 8'(3*i+1), 8'(3*i)};
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_data  = '0;
        i_pix_last  = 1'b0;
        i_full      = 1'b0;
        repeat (2) @(posedge system_clk);
        #1 rst_n = 1'b1;
        got_q.delete();
    endtask

    task automatic send_pix(input logic [23:0] d, input logic l);
        int n;
        n = 0;
        i_pix_valid = 1'b1;
        i_pix_data  = d;
        i_pix_last  = l;
        @(negedge system_clk);
        while (!o_pix_ready && n < 1000) begin
            n++;
            @(negedge system_clk);
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ready stuck low, pixel=%06h", d);
        end
        @(posedge system_clk);
        #1;
        i_pix_valid = 1'b0;
        i_pix_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_data  = '0;
        i_pix_last  = 1'b0;
        i_full      = 1'b0;
        repeat (2) @(negedge system_clk);
        checks++; if (o_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got=%b exp=0", o_wren); end
        checks++; if (o_wrdata !== '0) begin errors++; $display("FAIL rst_wrdata got=%032h exp=0", o_wrdata); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        checks++; if (o_word_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", o_word_cnt); end
        @(posedge system_clk);
        #1 rst_n = 1'b1;
        @(negedge system_clk);
        checks++; if (o_pix_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", o_pix_ready); end
    endtask

    task automatic test_full_line();
        do_reset();
        for (int i = 0; i < 16; i++) send_pix(pix(i), (i == 15));
        repeat (4) @(negedge system_clk);
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL line_words got=%0d exp=3", got_q.size()); end
        if (got_q.size() >= 3) begin
            checks++; if (got_q[0] !== W0) begin errors++; $display("FAIL line_w0 got=%032h exp=%032h", got_q[0], W0); end
            checks++; if (got_q[1] !== W1) begin errors++; $display("FAIL line_w1 got=%032h exp=%032h", got_q[1], W1); end
            checks++; if (got_q[2][127:120] !== 8'h2F) begin errors++; $display("FAIL line_w2_top got=%02h exp=2f", got_q[2][127:120]); end
            checks++; if (got_q[2] !== W2) begin errors++; $display("FAIL line_w2 got=%032h exp=%032h", got_q[2], W2); end
        end
        checks++; if (o_word_cnt !== 16'd3) begin errors++; $display("FAIL line_cnt got=%0d exp=3", o_word_cnt); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL line_idle_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_flush();
        int low_cnt;
        do_reset();
        for (int i = 0; i < 6; i++) send_pix(pix(i), (i == 5));
        low_cnt = 0;
        repeat (4) begin
            @(negedge system_clk);
            if (!o_pix_ready) low_cnt++;
        end
        checks++; if (low_cnt !== 1) begin errors++; $display("FAIL flush_ready_low got=%0d exp=1", low_cnt); end
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL flush_words got=%0d exp=2", got_q.size()); end
        if (got_q.size() >= 2) begin
            checks++; if (got_q[0] !== W0) begin errors++; $display("FAIL flush_w0 got=%032h exp=%032h", got_q[0], W0); end
            checks++; if (got_q[1] !== WF) begin errors++; $display("FAIL flush_w1 got=%032h exp=%032h", got_q[1], WF); end
        end
        checks++; if (o_word_cnt !== 16'd2) begin errors++; $display("FAIL flush_cnt got=%0d exp=2", o_word_cnt); end
    endtask

    task automatic test_partial();
        do_reset();
        for (int i = 0; i < 5; i++) send_pix(pix(i), (i == 4));
        @(negedge system_clk);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL part_busy_write got=%b exp=1", o_busy); end
        checks++; if (o_wren !== 1'b1) begin errors++; $display("FAIL part_wren got=%b exp=1", o_wren); end
        @(negedge system_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL part_busy_after got=%b exp=0", o_busy); end
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL part_words got=%0d exp=1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== WP) begin errors++; $display("FAIL part_w0 got=%032h exp=%032h", got_q[0], WP); end
        end
        checks++; if (o_word_cnt !== 16'd1) begin errors++; $display("FAIL part_cnt got=%0d exp=1", o_word_cnt); end
    endtask

    task automatic test_backpressure();
        int bad_wren, bad_data, bad_ready;
        do_reset();
        for (int i = 0; i < 6; i++) send_pix(pix(i), 1'b0);
        i_full = 1'b1;
        bad_wren = 0; bad_data = 0; bad_ready = 0;
        repeat (10) begin
            @(negedge system_clk);
            if (o_wren !== 1'b1) bad_wren++;
            if (o_wrdata !== W0) bad_data++;
            if (o_pix_ready !== 1'b0) bad_ready++;
        end
        checks++; if (bad_wren !== 0) begin errors++; $display("FAIL bp_wren_hold bad_cycles=%0d exp=0", bad_wren); end
        checks++; if (bad_data !== 0) begin errors++; $display("FAIL bp_data_hold bad_cycles=%0d exp=0", bad_data); end
        checks++; if (bad_ready !== 0) begin errors++; $display("FAIL bp_ready_low bad_cycles=%0d exp=0", bad_ready); end
        checks++; if (o_word_cnt !== 16'd0) begin errors++; $display("FAIL bp_cnt_stall got=%0d exp=0", o_word_cnt); end
        @(posedge system_clk);
        #1 i_full = 1'b0;
        repeat (3) @(negedge system_clk);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL bp_words got=%0d exp=1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== W0) begin errors++; $display("FAIL bp_w0 got=%032h exp=%032h", got_q[0], W0); end
        end
        checks++; if (o_word_cnt !== 16'd1) begin errors++; $display("FAIL bp_cnt got=%0d exp=1", o_word_cnt); end
        checks++; if (o_wren !== 1'b0) begin errors++; $display("FAIL bp_wren_drop got=%b exp=0", o_wren); end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [127:0] e, g;
        do_reset();
        tx_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 48; i++) send_pix(pix(i), (i == 47));
                tx_done = 1'b1;
            end
            begin
                int n;
                n = 0;
                while (!tx_done && n < 5000) begin
                    @(posedge system_clk);
                    #1 i_full = 1'($urandom_range(0, 1));
                    n++;
                end
            end
        join
        i_full = 1'b0;
        repeat (6) @(negedge system_clk);
        exp_q.delete();
        for (int k = 0; k < 9; k++) begin
            for (int b = 0; b < 16; b++) e[8*b +: 8] = 8'(16*k + b);
            exp_q.push_back(e);
        end
        checks++; if (got_q.size() !== 9) begin errors++; $display("FAIL b2b_words got=%0d exp=9", got_q.size()); end
        bad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            if (g !== e) begin
                bad++;
                $display("FAIL b2b_word got=%032h exp=%032h", g, e);
            end
        end
        checks++; if (bad !== 0 || exp_q.size() !== 0) begin errors++; $display("FAIL b2b_stream bad=%0d missing=%0d exp=0", bad, exp_q.size()); end
        checks++; if (o_word_cnt !== 16'd9) begin errors++; $display("FAIL b2b_cnt got=%0d exp=9", o_word_cnt); end
    endtask

    task automatic test_reset_mid();
        got_q.delete();
        for (int i = 0; i < 3; i++) send_pix(pix(i), 1'b0);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got=%b exp=1", o_busy); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (o_word_cnt !== 16'd0) begin errors++; $display("FAIL rmid_cnt got=%0d exp=0", o_word_cnt); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", o_busy); end
        @(posedge system_clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) send_pix(pix(i), 1'b0);
        i_full = 1'b1;
        @(negedge system_clk);
        checks++; if (o_wren !== 1'b1) begin errors++; $display("FAIL rmid_pending got=%b exp=1", o_wren); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (o_wren !== 1'b0) begin errors++; $display("FAIL rmid_wren_async got=%b exp=0", o_wren); end
        checks++; if (o_wrdata !== '0) begin errors++; $display("FAIL rmid_wrdata got=%032h exp=0", o_wrdata); end
        i_full = 1'b0;
        @(posedge system_clk);
        #1 rst_n = 1'b1;
        got_q.delete();

        for (int i = 0; i < 5; i++) send_pix(pix(i), (i == 4));
        repeat (3) @(negedge system_clk);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rmid_words got=%0d exp=1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== WP) begin errors++; $display("FAIL rmid_fresh got=%032h exp=%032h", got_q[0], WP); end
        end
        checks++; if (o_word_cnt !== 16'd1) begin errors++; $display("FAIL rmid_cnt_after got=%0d exp=1", o_word_cnt); end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        tx_done = 1'b0;
        test_reset();
        test_full_line();
        test_flush();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
